// File: rtl/axi_adc_jesd204_pkg.sv
// axi_adc_jesd204_pkg: shared scan FSM encoding, PN code constants and defaults.
package axi_adc_jesd204_pkg;
    typedef enum logic [2:0] {S_IDLE, S_SELECT, S_SETTLE, S_LOCK, S_DWELL, S_DONE} scan_state_e;
    localparam int SETTLE_CYCLES_DEF = 8;
    localparam logic [3:0] PN9 = 4'd0;
    localparam logic [3:0] PN23 = 4'd1;
    function automatic int max3(int a, int b, int c);
        return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
    endfunction
endpackage

// File: rtl/axi_adc_jesd204_pn_scan_if.sv
// axi_adc_jesd204_pn_scan_if: scan control/result bundle between the register side and PN monitors.
// scan_err_count exists only with AXI_ADC_JESD204_PN_SCAN_ERR_COUNT_EN.
interface axi_adc_jesd204_pn_scan_if #(
    parameter int NUM_CHANNELS = 4,
    parameter int LOCK_TIMEOUT_W = 16,
    parameter int DWELL_W = 20
);
    logic scan_start;
    logic [NUM_CHANNELS-1:0] scan_chan_mask;
    logic [LOCK_TIMEOUT_W-1:0] scan_lock_timeout;
    logic [DWELL_W-1:0] scan_dwell;
    logic [4*NUM_CHANNELS-1:0] cfg_pnseq_sel;
    logic [4*NUM_CHANNELS-1:0] adc_pnseq_sel;
    logic [NUM_CHANNELS-1:0] adc_pn_oos;
    logic [NUM_CHANNELS-1:0] adc_pn_err;
    logic scan_busy;
    logic scan_done;
    logic [NUM_CHANNELS-1:0] scan_pass;
    logic [NUM_CHANNELS-1:0] scan_fail_lock;
    logic [NUM_CHANNELS-1:0] scan_fail_err;
`ifdef AXI_ADC_JESD204_PN_SCAN_ERR_COUNT_EN
    logic [16*NUM_CHANNELS-1:0] scan_err_count;
`endif
    modport master (
        output scan_start, scan_chan_mask, scan_lock_timeout, scan_dwell, cfg_pnseq_sel, adc_pn_oos, adc_pn_err,
        input adc_pnseq_sel, scan_busy, scan_done, scan_pass, scan_fail_lock, scan_fail_err
`ifdef AXI_ADC_JESD204_PN_SCAN_ERR_COUNT_EN
        , scan_err_count
`endif
    );
    modport slave (
        input scan_start, scan_chan_mask, scan_lock_timeout, scan_dwell, cfg_pnseq_sel, adc_pn_oos, adc_pn_err,
        output adc_pnseq_sel, scan_busy, scan_done, scan_pass, scan_fail_lock, scan_fail_err
`ifdef AXI_ADC_JESD204_PN_SCAN_ERR_COUNT_EN
        , scan_err_count
`endif
    );
endinterface

// File: rtl/axi_adc_jesd204_pn_scan_timer.sv
// axi_adc_jesd204_pn_scan_timer: loadable down-counter that stops at zero.
module axi_adc_jesd204_pn_scan_timer #(
    parameter int W = 20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] value_i,
    output logic         zero_o
);
    logic [W-1:0] cnt_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else cnt_q <= load_i ? value_i : (cnt_q == '0 ? cnt_q : cnt_q - 1'b1);
    end
    assign zero_o = cnt_q == '0;
endmodule

// File: rtl/axi_adc_jesd204_pn_scan.sv
// axi_adc_jesd204_pn_scan: walks enabled ADC channels, forces the test PN code and records lock/error results.
// Optional saturating per-channel error counters: AXI_ADC_JESD204_PN_SCAN_ERR_COUNT_EN.
module axi_adc_jesd204_pn_scan
    import axi_adc_jesd204_pkg::*;
#(
    parameter int NUM_CHANNELS = 4,
    parameter logic [3:0] PNSEQ_CODE = PN9,
    parameter int LOCK_TIMEOUT_W = 16,
    parameter int DWELL_W = 20,
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
    input logic adc_clk,
    input logic adc_rst,
    axi_adc_jesd204_pn_scan_if.slave p
);
    localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int TW = max3(LOCK_TIMEOUT_W, DWELL_W, $clog2(SETTLE_CYCLES + 1));
    scan_state_e state_q, state_d;
    logic [NUM_CHANNELS-1:0] mask_q, mask_d, pass_q, pass_d, fl_q, fl_d, fe_q, fe_d;
    logic [LOCK_TIMEOUT_W-1:0] tmo_q, tmo_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [CW-1:0] ch_q, ch_d, low_ch;
    logic [TW-1:0] ld_val;
    logic ld, zero, hit, fwd;
    axi_adc_jesd204_pn_scan_timer #(.W(TW)) u_timer (
        .clk(adc_clk), .rst(adc_rst), .load_i(ld), .value_i(ld_val), .zero_o(zero)
    );
    always_comb begin
        low_ch = '0;
        for (int i = NUM_CHANNELS - 1; i >= 0; i--) if (mask_q[i]) low_ch = CW'(i);
    end
    assign hit = p.adc_pn_err[ch_q] | p.adc_pn_oos[ch_q];
    always_comb begin
        state_d = state_q;
        mask_d = mask_q;
        tmo_d = tmo_q;
        dwell_d = dwell_q;
        ch_d = ch_q;
        pass_d = pass_q;
        fl_d = fl_q;
        fe_d = fe_q;
        ld = 1'b0;
        ld_val = '0;
        case (state_q)
            S_IDLE: if (p.scan_start) begin
                state_d = S_SELECT;
                mask_d = p.scan_chan_mask;
                tmo_d = p.scan_lock_timeout;
                dwell_d = p.scan_dwell;
                pass_d = '0;
                fl_d = '0;
                fe_d = '0;
            end
            S_SELECT: if (|mask_q) begin
                ch_d = low_ch;
                mask_d[low_ch] = 1'b0;
                ld = 1'b1;
                ld_val = TW'(SETTLE_CYCLES - 1);
                state_d = S_SETTLE;
            end else state_d = S_DONE;
            S_SETTLE: if (zero) begin
                ld = 1'b1;
                ld_val = TW'(tmo_q);
                state_d = S_LOCK;
            end
            S_LOCK: if (!p.adc_pn_oos[ch_q]) begin
                ld = 1'b1;
                ld_val = (dwell_q == '0) ? '0 : TW'(dwell_q - 1'b1);
                state_d = S_DWELL;
            end else if (zero) begin
                fl_d[ch_q] = 1'b1;
                state_d = S_SELECT;
            end
            S_DWELL: begin
                fe_d[ch_q] = fe_q[ch_q] | hit;
                if (zero) begin
                    pass_d[ch_q] = !(fe_q[ch_q] | hit);
                    state_d = S_SELECT;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge adc_clk or posedge adc_rst) begin
        if (adc_rst) begin
            state_q <= S_IDLE;
            mask_q <= '0;
            tmo_q <= '0;
            dwell_q <= '0;
            ch_q <= '0;
            pass_q <= '0;
            fl_q <= '0;
            fe_q <= '0;
        end else begin
            state_q <= state_d;
            mask_q <= mask_d;
            tmo_q <= tmo_d;
            dwell_q <= dwell_d;
            ch_q <= ch_d;
            pass_q <= pass_d;
            fl_q <= fl_d;
            fe_q <= fe_d;
        end
    end
    // SELECT is left out so no channel is forced before one has actually been picked
    assign fwd = state_q inside {S_SETTLE, S_LOCK, S_DWELL};
    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_sel
        assign p.adc_pnseq_sel[4*c +: 4] = (fwd && ch_q == CW'(c)) ? PNSEQ_CODE : p.cfg_pnseq_sel[4*c +: 4];
    end
    assign p.scan_busy = !(state_q inside {S_IDLE, S_DONE});
    assign p.scan_done = state_q == S_DONE;
    assign p.scan_pass = pass_q;
    assign p.scan_fail_lock = fl_q;
    assign p.scan_fail_err = fe_q;
`ifdef AXI_ADC_JESD204_PN_SCAN_ERR_COUNT_EN
    logic [NUM_CHANNELS-1:0][15:0] cnt_q;
    always_ff @(posedge adc_clk or posedge adc_rst) begin
        if (adc_rst) cnt_q <= '0;
        else if (state_q == S_IDLE && p.scan_start) cnt_q <= '0;
        else if (state_q == S_DWELL && p.adc_pn_err[ch_q] && cnt_q[ch_q] != 16'hFFFF) cnt_q[ch_q] <= cnt_q[ch_q] + 16'd1;
    end
    assign p.scan_err_count = cnt_q;
`endif
endmodule

// File: tb/tb_axi_adc_jesd204_pn_scan.sv
// tb_axi_adc_jesd204_pn_scan: randomized bench with a sequential scan model and an emulated PN monitor per channel.
module tb_axi_adc_jesd204_pn_scan;
    import axi_adc_jesd204_pkg::*;
    localparam int NC = 4;
    localparam int SET = SETTLE_CYCLES_DEF;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;
    axi_adc_jesd204_pn_scan_if #(.NUM_CHANNELS(NC), .LOCK_TIMEOUT_W(16), .DWELL_W(20)) s ();
    axi_adc_jesd204_pn_scan #(
        .NUM_CHANNELS(NC), .PNSEQ_CODE(PN9), .LOCK_TIMEOUT_W(16), .DWELL_W(20), .SETTLE_CYCLES(SET)
    ) dut (.adc_clk(clk), .adc_rst(rst), .p(s.slave));

    int n_chk = 0, n_pass = 0, n_done = 0;
    bit cmp_en = 0;
    int seen_q[$];
    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // reference model: expected outputs for the cycle following each edge
    logic m_busy, m_done;
    int m_ch;
    logic [NC-1:0] m_pass, m_fl, m_fe;
    logic [15:0] m_cnt[NC];
    bit m_rst;
    task automatic tick();
        @(posedge clk or posedge rst);
        m_rst = rst;
    endtask
    task automatic m_clear();
        m_busy = 0; m_done = 0; m_ch = -1; m_pass = '0; m_fl = '0; m_fe = '0;
        for (int c = 0; c < NC; c++) m_cnt[c] = '0;
    endtask
    task automatic run_scan();
        logic [NC-1:0] mask;
        int t, d;
        bit locked, bad;
        mask = s.scan_chan_mask;
        t = int'(s.scan_lock_timeout);
        d = (s.scan_dwell == 0) ? 1 : int'(s.scan_dwell);
        m_clear();
        m_busy = 1;
        for (int c = 0; c < NC; c++) begin
            if (!mask[c]) continue;
            tick(); if (m_rst) return;
            m_ch = c;
            for (int k = 0; k < SET; k++) begin tick(); if (m_rst) return; end
            locked = 0;
            for (int k = 0; k <= t; k++) begin
                tick(); if (m_rst) return;
                if (!s.adc_pn_oos[c]) begin locked = 1; break; end
            end
            if (!locked) m_fl[c] = 1;
            else begin
                bad = 0;
                for (int j = 0; j < d; j++) begin
                    tick(); if (m_rst) return;
                    if (s.adc_pn_err[c] || s.adc_pn_oos[c]) begin bad = 1; m_fe[c] = 1; end
                    if (s.adc_pn_err[c] && m_cnt[c] != 16'hFFFF) m_cnt[c] = m_cnt[c] + 16'd1;
                end
                m_pass[c] = !bad;
            end
            m_ch = -1;
        end
        tick(); if (m_rst) return;
        m_busy = 0; m_done = 1;
        tick(); if (m_rst) return;
        m_done = 0;
    endtask
    initial begin
        m_clear();
        forever begin
            tick();
            if (m_rst) begin m_clear(); continue; end
            if (s.scan_start) begin
                run_scan();
                if (m_rst) m_clear();
            end
        end
    end

    // PN monitor emulation: locks lat cycles after the channel is switched to the test code
    int lat[NC], fc[NC];
    int err_prob = 0, err_pulse = 0;
    bit err_hold = 0;
    initial begin
        for (int c = 0; c < NC; c++) begin fc[c] = 0; lat[c] = 1000000; end
        forever begin
            @(posedge clk);
            #3;
            for (int c = 0; c < NC; c++) begin
                if (s.adc_pnseq_sel[4*c +: 4] != s.cfg_pnseq_sel[4*c +: 4]) begin
                    fc[c]++;
                    s.adc_pn_oos[c] = fc[c] < lat[c];
                    s.adc_pn_err[c] = err_hold || (err_pulse != 0 && fc[c] == lat[c] + err_pulse)
                                      || ($urandom_range(0, 999) < err_prob);
                end else begin
                    fc[c] = 0;
                    s.adc_pn_oos[c] = 1'($urandom_range(0, 1));
                    s.adc_pn_err[c] = 1'($urandom_range(0, 1));
                end
            end
        end
    end

    initial begin
        logic [4*NC-1:0] exp_sel;
        forever begin
            @(negedge clk);
            if (cmp_en && !rst) begin
                exp_sel = s.cfg_pnseq_sel;
                if (m_ch >= 0) exp_sel[4*m_ch +: 4] = PN9;
                chk("busy", s.scan_busy, m_busy);
                chk("done", s.scan_done, m_done);
                chk("pass", s.scan_pass, m_pass);
                chk("fail_lock", s.scan_fail_lock, m_fl);
                chk("fail_err", s.scan_fail_err, m_fe);
                chk("pnseq_sel", s.adc_pnseq_sel, exp_sel);
`ifdef AXI_ADC_JESD204_PN_SCAN_ERR_COUNT_EN
                for (int c = 0; c < NC; c++) chk("err_count", s.scan_err_count[16*c +: 16], m_cnt[c]);
`endif
                if (s.scan_done) n_done++;
                for (int c = 0; c < NC; c++)
                    if (s.adc_pnseq_sel[4*c +: 4] != s.cfg_pnseq_sel[4*c +: 4] && (seen_q.size() == 0 || seen_q[$] != c))
                        seen_q.push_back(c);
            end
        end
    end

    logic [4*NC-1:0] cfg_v;
    task automatic new_cfg();
        for (int c = 0; c < NC; c++) cfg_v[4*c +: 4] = 4'($urandom_range(1, 15));
        s.cfg_pnseq_sel = cfg_v;
    endtask
    task automatic do_scan(input logic [NC-1:0] m, input int t, input int d, input bit spur, input int budget, output int lat_o);
        s.scan_chan_mask = m; s.scan_lock_timeout = 16'(t); s.scan_dwell = 20'(d); s.scan_start = 1;
        step();
        s.scan_start = spur; s.scan_chan_mask = ~m; s.scan_lock_timeout = '0; s.scan_dwell = 20'd1;
        step();
        s.scan_start = 0;
        lat_o = -1;
        for (int i = 2; i < budget; i++) begin
            @(negedge clk);
            if (s.scan_done) begin lat_o = i; break; end
        end
        if (lat_o < 0) chk("done_timeout", 0, 1);
        step();
    endtask

    initial begin
        int l, nd0;
        s.scan_start = 0; s.scan_chan_mask = '0; s.scan_lock_timeout = '0; s.scan_dwell = '0;
        s.adc_pn_oos = '1; s.adc_pn_err = '0;
        new_cfg();
        #1 rst = 1;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_busy", s.scan_busy, 0);
        chk("rst_done", s.scan_done, 0);
        chk("rst_results", {s.scan_pass, s.scan_fail_lock, s.scan_fail_err}, '0);
        chk("rst_sel", s.adc_pnseq_sel, cfg_v);
        rst = 0;
        cmp_en = 1;
        step();
        // two channels lock 3 cycles into LOCK, clean dwell
        for (int c = 0; c < NC; c++) lat[c] = SET + 4;
        seen_q.delete();
        nd0 = n_done;
        do_scan(4'b0101, 20, 100, 0, 2000, l);
        chk("t1_pass", s.scan_pass, 4'b0101);
        chk("t1_fail", {s.scan_fail_lock, s.scan_fail_err}, '0);
        chk("t1_done_once", 64'(n_done - nd0), 1);
        chk("t1_order_len", 64'(seen_q.size()), 2);
        if (seen_q.size() == 2) begin
            chk("t1_first_ch", 64'(seen_q[0]), 0);
            chk("t1_second_ch", 64'(seen_q[1]), 2);
        end
        // never locks: timeout after 51 LOCK cycles
        for (int c = 0; c < NC; c++) lat[c] = 1000000;
        do_scan(4'b0010, 50, 10, 0, 2000, l);
        chk("t2_fail_lock", s.scan_fail_lock, 4'b0010);
        chk("t2_pass", s.scan_pass, 0);
        chk("t2_done_lat", 64'(l), 64'(SET + 54));
        // single error pulse at dwell cycle 10
        for (int c = 0; c < NC; c++) lat[c] = SET + 4;
        err_pulse = 10;
        do_scan(4'b0001, 20, 64, 0, 2000, l);
        chk("t3_fail_err", s.scan_fail_err, 4'b0001);
        chk("t3_pass", s.scan_pass, 0);
`ifdef AXI_ADC_JESD204_PN_SCAN_ERR_COUNT_EN
        chk("t3_err_count", s.scan_err_count[15:0], 16'd1);
`endif
        err_pulse = 0;
        // empty mask with a second start while busy
        nd0 = n_done;
        do_scan(4'b0000, 5, 5, 1, 200, l);
        chk("t4_done_lat", 64'(l), 2);
        chk("t4_results", {s.scan_pass, s.scan_fail_lock, s.scan_fail_err}, '0);
        chk("t4_done_once", 64'(n_done - nd0), 1);
        // reset during DWELL
        for (int c = 0; c < NC; c++) lat[c] = SET + 2;
        err_prob = 500;
        s.scan_chan_mask = 4'b0001; s.scan_lock_timeout = 16'd10; s.scan_dwell = 20'd1000; s.scan_start = 1;
        step();
        s.scan_start = 0;
        repeat (40) step();
        chk("t5_pre_busy", s.scan_busy, 1);
        chk("t5_pre_fail_err", s.scan_fail_err, 4'b0001);
        #1 rst = 1;
        #1;
        chk("t5_busy", s.scan_busy, 0);
        chk("t5_results", {s.scan_pass, s.scan_fail_lock, s.scan_fail_err}, '0);
        chk("t5_sel", s.adc_pnseq_sel, cfg_v);
        step();
        rst = 0;
        step();
        // randomized scans
        for (int it = 0; it < 25; it++) begin
            int ep[4] = '{0, 0, 30, 300};
            err_prob = ep[$urandom_range(0, 3)];
            for (int c = 0; c < NC; c++) lat[c] = $urandom_range(SET + 1, SET + 20);
            new_cfg();
            do_scan(4'($urandom_range(0, 15)), $urandom_range(0, 15), $urandom_range(0, 20), 1'($urandom_range(0, 1)), 2000, l);
        end
        err_prob = 0;
`ifdef AXI_ADC_JESD204_PN_SCAN_ERR_COUNT_EN
        // error held through a long dwell saturates the counter
        for (int c = 0; c < NC; c++) lat[c] = SET + 2;
        err_hold = 1;
        do_scan(4'b0001, 10, 65600, 0, 70000, l);
        err_hold = 0;
        chk("t6_err_count", s.scan_err_count[15:0], 16'hFFFF);
        chk("t6_fail_err", s.scan_fail_err, 4'b0001);
`endif
        repeat (3) step();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
